alu_exec_stage: RTL
===================

# alu_exec_stage

Execute stage that consumes the 3-bit ALUCtrl code produced by the instruction-decode datapath and applies it to two operands. It sits directly downstream of the decode/ALU-control logic. It has a registered result, a valid/ready handshake on both sides, and a one-entry skid buffer, so back-pressure never drops or duplicates an operation.

## Interface
- WIDTH, 32, operand/result width (≥ 2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream offers an operation
- in_ready  out  1  stage can accept; = ~skid_valid & ~reset
- alu_ctrl  in  3  ALUCtrl code from decode
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only)
- illegal  out  1  alu_ctrl was an unassigned code

## Operation
- Codes:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB (a−b)
  - 111 SLT: result = {0…,1} if signed a < b, else 0. Computed as sign(a−b) XOR overflow, so it is correct across overflow.
- Codes 011, 100, 101 are illegal.
  - result = 0, zero = 1, overflow = 0, illegal = 1.
  - The operation still flows through the handshake normally.
- ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operands have the same sign (ADD) or different signs (SUB) and the result sign differs from a.
  - overflow = 0 for AND/OR/SLT.
- zero and illegal are computed with result and stored alongside it. Output signals are never recomputed after capture.
- Transfer rules:
  - Accept: in_valid & in_ready at a rising edge.
  - Deliver: out_valid & out_ready at a rising edge.
- On accept, the computed {result, zero, overflow, illegal} goes to:
  - the output register, if it is empty or delivering in the same cycle;
  - otherwise, the skid register (skid_valid ← 1).
- On deliver while skid_valid: output register ← skid contents, skid_valid ← 0.
  - No accept is possible that cycle, because in_ready = 0.
- On deliver with no accept and no skid: out_valid ← 0.
- Order is strictly preserved. No operation is lost or duplicated.
- Reset (synchronous, any state, including mid-stall):
  - out_valid = 0, skid_valid = 0, result = 0, zero = 0, overflow = 0, illegal = 0.
  - in_ready = 0 while reset is high and 1 in the first cycle after reset falls.
  - Any operation in flight is discarded.

## Timing
- Latency: accepted at edge N → out_valid high after edge N with its result.
- Throughput: one operation per cycle while out_ready = 1.
- Stall entry:
  - If out_ready is low while an accept occurs, that operation lands in skid.
  - in_ready falls after that same edge.
  - At most one extra operation is absorbed.
- Stall exit: the first edge with out_ready = 1 delivers the output register, moves skid to output, and raises in_ready for the next cycle.
- Output values are stable while out_valid & ~out_ready.
- in_ready depends only on flops and reset, never combinationally on out_ready.

## Structure
- Package alu_pkg:
  - enum alu_ctrl_e with ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - The same package is used by the decode block that generates ALUCtrl.
- Sub-module alu_core: purely combinational.
  - Inputs: ctrl, a, b.
  - Outputs: result, zero, overflow, illegal.
- alu_exec_stage holds only the output register, the skid register and the handshake control.

## Test plan
- Reset then streaming, out_ready = 1, WIDTH = 32: ADD 5+7, SUB 3−5, AND F0F0_F0F0&0FF0_0FF0, OR 0000_00A0|0000_000B → 12, FFFF_FFFE, 00F0_00F0, 0000_00AB. Results appear one per cycle at 1-cycle latency; zero = 0 throughout.
- Overflow and SLT:
  - ADD 7FFF_FFFF+1 → 8000_0000, overflow = 1.
  - SUB 8000_0000−1 → 7FFF_FFFF, overflow = 1.
  - SLT a=8000_0000, b=1 → 1.
  - SLT a=1, b=FFFF_FFFF → 0.
  - SUB 9−9 → 0, zero = 1.
- Illegal codes 011/100/101 with a=b=FFFF_FFFF → result = 0, zero = 1, illegal = 1, overflow = 0. The next legal operation clears illegal.
- Back-pressure:
  - Hold out_ready = 0 for 5 cycles while in_valid = 1 with ADD 1+1, 2+2, 3+3.
  - Only the first two are accepted; in_ready = 0 from the cycle after the second accept.
  - Release out_ready → 2, 4, 6 are delivered in order, without loss or duplication.
- Reset mid-stall: with both the output register and skid full, assert reset for 1 cycle → out_valid = 0 and all outputs 0. in_ready = 1 the next cycle, and the next accepted ADD 2+2 yields 4 with no stale results.
- Random valid/ready toggling over 1000 operations against a scoreboard model: the in-order result stream matches exactly, and outputs are stable during stalls.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU control encodings and result flag bundle.
// Shared by decode (which produces ALUCtrl) and the execute stage.
// No logic; types and constants only.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT with zero, signed-overflow and illegal-code flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing stage owns flow control.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             slt;

    assign sum  = a + b;
    assign diff = a - b;

    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1]  != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
    // Sign of the wrapped difference is wrong exactly when the subtraction overflowed.
    assign slt     = diff[WIDTH-1] ^ ovf_sub;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result   = sum;
                overflow = ovf_add;
            end
            ALU_SUB: begin
                result   = diff;
                overflow = ovf_sub;
            end
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: registered result with valid/ready on both sides and a one-entry skid.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: one op absorbed into skid when out_ready is low; in_ready drops while skid is full.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    logic [WIDTH-1:0] core_res;
    alu_flags_t       core_flags;

    logic [WIDTH-1:0] out_res;
    alu_flags_t       out_flags;
    logic [WIDTH-1:0] skid_res;
    alu_flags_t       skid_flags;
    logic             skid_valid;

    logic             accept;
    logic             deliver;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .ctrl     (alu_ctrl),
        .a        (op_a),
        .b        (op_b),
        .result   (core_res),
        .zero     (core_flags.zero),
        .overflow (core_flags.overflow),
        .illegal  (core_flags.illegal)
    );

    // Registered-only ready: never a combinational path from out_ready.
    assign in_ready = ~skid_valid & ~reset;
    assign accept   = in_valid & in_ready;
    assign deliver  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_res    <= '0;
            out_flags  <= '0;
            skid_valid <= 1'b0;
            skid_res   <= '0;
            skid_flags <= '0;
        end else if (accept) begin
            if (~out_valid | deliver) begin
                out_valid <= 1'b1;
                out_res   <= core_res;
                out_flags <= core_flags;
            end else begin
                skid_valid <= 1'b1;
                skid_res   <= core_res;
                skid_flags <= core_flags;
            end
        end else if (deliver) begin
            if (skid_valid) begin
                out_res    <= skid_res;
                out_flags  <= skid_flags;
                skid_valid <= 1'b0;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

    assign result   = out_res;
    assign zero     = out_flags.zero;
    assign overflow = out_flags.overflow;
    assign illegal  = out_flags.illegal;

endmodule
